// File: rtl/system_ctrl_pkg.sv
// Shared system definitions: command codes, datapath select encodings and
// the controller state encoding used by system_ctrl and the datapath.
package system_ctrl_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_REG_WR = 8'hAA;
    localparam logic [7:0] CMD_REG_RD = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;

    // Register-file address source select
    localparam logic [1:0] ADD_SRC_OP0 = 2'b00;
    localparam logic [1:0] ADD_SRC_OP1 = 2'b01;
    localparam logic [1:0] ADD_SRC_RX  = 2'b10;

    // TX data source select
    localparam logic OUT_SRC_ALU = 1'b0;
    localparam logic OUT_SRC_RF  = 1'b1;

    // Register-file data source select
    localparam logic DATA_SRC_RX = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WR_ADDR  = 4'd1,
        ST_WR_DATA  = 4'd2,
        ST_WR_EXEC  = 4'd3,
        ST_RD_ADDR  = 4'd4,
        ST_RD_WAIT  = 4'd5,
        ST_OPA      = 4'd6,
        ST_WR_A     = 4'd7,
        ST_OPB      = 4'd8,
        ST_WR_B     = 4'd9,
        ST_FUNC     = 4'd10,
        ST_ALU_WAIT = 4'd11,
        ST_TX_LOAD  = 4'd12,
        ST_TX_SEND  = 4'd13
    } state_e;

    // States in which the wait counter advances
    function automatic logic is_wait_state(input state_e s);
        logic w_res;
        case (s)
            ST_RD_WAIT, ST_ALU_WAIT, ST_TX_SEND: w_res = 1'b1;
            default:                             w_res = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/system_ctrl.sv
// Command-frame controller: decodes UART command bytes and sequences the
// register file, ALU and TX path. Load/write strobes are combinational so
// they line up with the byte the datapath captures in the same cycle.
module system_ctrl
    import system_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rx_data,
    input  logic             i_rx_data_valid,
    input  logic             i_reg_file_valid,
    input  logic             i_alu_valid,
    input  logic             i_tx_busy,
    output logic             o_alu_en,
    output logic             o_ld_alu_func,
    output logic             o_alu_clk_en,
    output logic             o_en_r,
    output logic             o_en_w,
    output logic             o_ld_rf_data,
    output logic             o_rf_data_source,
    output logic             o_ld_rf_add,
    output logic [1:0]       o_rf_add_source,
    output logic             o_output_source,
    output logic             o_tx_valid,
    output logic             o_err
);

    localparam int              CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TIMEOUT_CNT = CW'(TIMEOUT);

    state_e          r_state;
    state_e          w_state_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_out_src;
    logic            w_out_src_next;
    logic            w_timeout;

    assign w_timeout = (r_wait_cnt == TIMEOUT_CNT);

    // State, wait counter and latched TX source registers
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= {CW{1'b0}};
            r_out_src  <= OUT_SRC_ALU;
        end else begin
            r_state   <= w_state_next;
            r_out_src <= w_out_src_next;
            if (w_state_next != r_state) begin
                r_wait_cnt <= {CW{1'b0}};
            end else if (is_wait_state(r_state)) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
        end
    end

    // Next-state decode and control outputs; everything is held at 0 while
    // reset is low so no datapath write slips out of an abandoned frame
    always_comb begin
        w_state_next     = r_state;
        w_out_src_next   = r_out_src;
        o_alu_en         = 1'b0;
        o_ld_alu_func    = 1'b0;
        o_alu_clk_en     = 1'b0;
        o_en_r           = 1'b0;
        o_en_w           = 1'b0;
        o_ld_rf_data     = 1'b0;
        o_rf_data_source = 1'b0;
        o_ld_rf_add      = 1'b0;
        o_rf_add_source  = 2'b00;
        o_output_source  = 1'b0;
        o_tx_valid       = 1'b0;
        o_err            = 1'b0;
        if (!i_rst) begin
            w_state_next   = ST_IDLE;
            w_out_src_next = OUT_SRC_ALU;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_data_valid) begin
                        if (i_rx_data == WIDTH'(CMD_REG_WR))      w_state_next = ST_WR_ADDR;
                        else if (i_rx_data == WIDTH'(CMD_REG_RD)) w_state_next = ST_RD_ADDR;
                        else if (i_rx_data == WIDTH'(CMD_ALU_OP)) w_state_next = ST_OPA;
                        else if (i_rx_data == WIDTH'(CMD_ALU))    w_state_next = ST_FUNC;
                        else                                      w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_WR_ADDR, ST_RD_ADDR: begin
                    if (i_rx_data_valid) begin
                        o_ld_rf_add     = 1'b1;
                        o_rf_add_source = ADD_SRC_RX;
                        w_state_next    = (r_state == ST_WR_ADDR) ? ST_WR_DATA : ST_RD_WAIT;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_WR_DATA: begin
                    if (i_rx_data_valid) begin
                        o_ld_rf_data     = 1'b1;
                        o_rf_data_source = DATA_SRC_RX;
                        w_state_next     = ST_WR_EXEC;
                    end else begin
                        w_state_next = ST_WR_DATA;
                    end
                end
                ST_OPA, ST_OPB: begin
                    if (i_rx_data_valid) begin
                        o_ld_rf_add      = 1'b1;
                        o_rf_add_source  = (r_state == ST_OPA) ? ADD_SRC_OP0 : ADD_SRC_OP1;
                        o_ld_rf_data     = 1'b1;
                        o_rf_data_source = DATA_SRC_RX;
                        w_state_next     = (r_state == ST_OPA) ? ST_WR_A : ST_WR_B;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_WR_EXEC: begin
                    o_en_w       = 1'b1;
                    w_state_next = ST_IDLE;
                end
                ST_WR_A: begin
                    o_en_w       = 1'b1;
                    w_state_next = ST_OPB;
                end
                ST_WR_B: begin
                    o_en_w       = 1'b1;
                    w_state_next = ST_FUNC;
                end
                ST_FUNC: begin
                    if (i_rx_data_valid) begin
                        o_ld_alu_func = 1'b1;
                        w_state_next  = ST_ALU_WAIT;
                    end else begin
                        w_state_next = ST_FUNC;
                    end
                end
                ST_RD_WAIT: begin
                    if (w_timeout) begin
                        o_err        = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        o_en_r = 1'b1;
                        if (i_reg_file_valid) begin
                            w_out_src_next = OUT_SRC_RF;
                            w_state_next   = ST_TX_LOAD;
                        end else begin
                            w_state_next = ST_RD_WAIT;
                        end
                    end
                end
                ST_ALU_WAIT: begin
                    if (w_timeout) begin
                        o_err        = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        o_alu_en     = 1'b1;
                        o_alu_clk_en = 1'b1;
                        if (i_alu_valid) begin
                            w_out_src_next = OUT_SRC_ALU;
                            w_state_next   = ST_TX_LOAD;
                        end else begin
                            w_state_next = ST_ALU_WAIT;
                        end
                    end
                end
                ST_TX_LOAD: begin
                    o_output_source = r_out_src;
                    w_state_next    = ST_TX_SEND;
                end
                ST_TX_SEND: begin
                    o_output_source = r_out_src;
                    if (w_timeout) begin
                        o_err        = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (!i_tx_busy) begin
                        o_tx_valid   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_TX_SEND;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

endmodule
